// File: rtl/ldpc_3gpp_dec_source.sv
// LDPC decoder input source: writes an LLR stream into a ping-pong column memory.
// Optional zero-fill of punctured columns 0/1 via macro LDPC_3GPP_DEC_SOURCE_PUNCT_FILL_EN.
//   state | meaning
//   IDLE  | wait for a free buffer, latch frame geometry
//   FILL  | write zeros into punctured columns 0 and 1
//   DO    | accept stream words and write them out
module ldpc_3gpp_dec_source #(
    parameter int pADDR_W  = 8,
    parameter int pDAT_W   = 8,
    parameter int pDAT_NUM = 4,
    parameter int pZC_W    = 9,
    parameter int pCOL_W   = 6,
    parameter int pTAG_W   = 4
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                iclkena,
    input  logic [pZC_W-1:0]    iused_zc,
    input  logic [pCOL_W-1:0]   iused_col,
    input  logic                iused_punct,
    input  logic                isop,
    input  logic                ieop,
    input  logic                ival,
    input  logic [pDAT_W-1:0]   idat,
    input  logic [pTAG_W-1:0]   itag,
    output logic                ordy,
    output logic                owrite,
    output logic                owbuf,
    output logic [pADDR_W-1:0]  owaddr,
    output logic [pDAT_NUM-1:0] owsel,
    output logic [pDAT_W-1:0]   owdat,
    output logic                ofull,
    output logic [pTAG_W-1:0]   otag,
    output logic                oeop_err,
    input  logic                iempty
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DO   = 2'd2;

    logic [1:0]          r_state;
    logic [pZC_W-1:0]    r_zc;
    logic [pCOL_W-1:0]   r_col;
    logic [pZC_W-1:0]    r_z;
    logic [pCOL_W-1:0]   r_c;
    logic [pDAT_NUM-1:0] r_sel;
    logic [pADDR_W-1:0]  r_base;
    logic                r_first;
    logic                r_early;
    logic                r_commit;
    logic [1:0]          r_cnt;
    logic                r_wbuf;
    logic                r_rbuf;
    logic [pTAG_W-1:0]   r_tag [2];

    logic w_start;
    logic w_acc;
    logic w_step;
    logic w_z_last;
    logic w_last;
    logic w_rel;
    logic w_fill_go;

    assign ordy     = (r_state == DO);
    assign w_acc    = ival & ordy;
    assign w_step   = (r_state == FILL) | w_acc;
    assign w_start  = (r_state == IDLE) & ~r_commit & (r_cnt != 2'd2);
    assign w_z_last = (r_z == r_zc - pZC_W'(1));
    assign w_last   = w_z_last & (r_c == r_col - pCOL_W'(1));
    assign w_rel    = iempty & (r_cnt != 2'd0);

`ifdef LDPC_3GPP_DEC_SOURCE_PUNCT_FILL_EN
    logic w_fill_last;
    assign w_fill_last = w_z_last & (r_c == pCOL_W'(1));
    assign w_fill_go   = iused_punct;
`else
    assign w_fill_go   = 1'b0 & iused_punct;
`endif

    assign ofull = (r_cnt != 2'd0);
    assign owbuf = r_wbuf;
    assign otag  = r_tag[r_rbuf];

    // FSM, word/column counters and registered write port
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_state  <= IDLE;
            r_zc     <= '0;
            r_col    <= '0;
            r_z      <= '0;
            r_c      <= '0;
            r_sel    <= '0;
            r_base   <= '0;
            r_commit <= 1'b0;
            owrite   <= 1'b0;
            owaddr   <= '0;
            owsel    <= '0;
            owdat    <= '0;
        end else if (iclkena) begin
            r_commit <= w_acc & w_last;
            owrite   <= w_step;
            if (w_step) begin
                owaddr <= r_base + pADDR_W'(r_z);
                owsel  <= r_sel;
                owdat  <= (r_state == DO) ? idat : '0;
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_zc    <= iused_zc;
                        r_col   <= iused_col;
                        r_state <= w_fill_go ? FILL : DO;
                    end
                end
`ifdef LDPC_3GPP_DEC_SOURCE_PUNCT_FILL_EN
                FILL: begin
                    if (w_fill_last)
                        r_state <= DO;
                end
`endif
                DO: begin
                    if (w_acc & w_last)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // Row base advances by one column height each time the bank select wraps
            if (w_start) begin
                r_z    <= '0;
                r_c    <= '0;
                r_sel  <= pDAT_NUM'(1);
                r_base <= '0;
            end else if (w_step) begin
                if (w_z_last) begin
                    r_z   <= '0;
                    r_c   <= r_c + pCOL_W'(1);
                    r_sel <= (r_sel << 1) | pDAT_NUM'(r_sel[pDAT_NUM-1]);
                    if (r_sel[pDAT_NUM-1])
                        r_base <= r_base + pADDR_W'(r_zc);
                end else begin
                    r_z <= r_z + pZC_W'(1);
                end
            end
        end
    end

    // Framing check, tag capture and buffer bookkeeping
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_first  <= 1'b0;
            r_early  <= 1'b0;
            oeop_err <= 1'b0;
            r_cnt    <= 2'd0;
            r_wbuf   <= 1'b0;
            r_rbuf   <= 1'b0;
            r_tag[0] <= '0;
            r_tag[1] <= '0;
        end else if (iclkena) begin
            if (w_start) begin
                r_first  <= 1'b1;
                r_early  <= 1'b0;
                oeop_err <= 1'b0;
            end else if (w_acc) begin
                r_first <= 1'b0;
                if (r_first)
                    r_tag[r_wbuf] <= itag;
                if (ieop & ~w_last)
                    r_early <= 1'b1;
                if ((r_first & ~isop) | (w_last & (r_early | ~ieop)))
                    oeop_err <= 1'b1;
            end
            if (r_commit)
                r_wbuf <= ~r_wbuf;
            if (w_rel)
                r_rbuf <= ~r_rbuf;
            case ({r_commit, w_rel})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_3gpp_dec_source.sv
// Directed self-checking bench for ldpc_3gpp_dec_source (default parameters).
module tb_ldpc_3gpp_dec_source;

    logic        iclk = 1'b0;
    logic        ireset = 1'b1;
    logic        iclkena = 1'b1;
    logic [8:0]  iused_zc = 9'd1;
    logic [5:0]  iused_col = 6'd1;
    logic        iused_punct = 1'b0;
    logic        isop = 1'b0, ieop = 1'b0, ival = 1'b0;
    logic [7:0]  idat = 8'd0;
    logic [3:0]  itag = 4'd0;
    logic        ordy, owrite, owbuf, ofull, oeop_err;
    logic [7:0]  owaddr, owdat;
    logic [3:0]  owsel, otag;
    logic        iempty = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    logic [20:0] wq[$];

    ldpc_3gpp_dec_source dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .iused_zc(iused_zc), .iused_col(iused_col), .iused_punct(iused_punct),
        .isop(isop), .ieop(ieop), .ival(ival), .idat(idat), .itag(itag),
        .ordy(ordy), .owrite(owrite), .owbuf(owbuf), .owaddr(owaddr),
        .owsel(owsel), .owdat(owdat), .ofull(ofull), .otag(otag),
        .oeop_err(oeop_err), .iempty(iempty)
    );

    always #5 iclk = ~iclk;

    always @(negedge iclk)
        if (owrite && iclkena) wq.push_back({owbuf, owaddr, owsel, owdat});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Expected write record {buf, addr, sel, dat} from the address map
    function automatic logic [20:0] exp_rec(input logic b, input int zc, input int c,
                                            input int z, input int d);
        logic [7:0] a;
        logic [3:0] s;
        a = 8'((c / 4) * zc + z);
        s = 4'(1 << (c % 4));
        return {b, a, s, 8'(d)};
    endfunction

    task automatic do_reset(input int zc, input int col, input bit punct);
        @(negedge iclk);
        ireset = 1'b1;
        ival = 1'b0; isop = 1'b0; ieop = 1'b0; iempty = 1'b0; iclkena = 1'b1;
        iused_zc = 9'(zc); iused_col = 6'(col); iused_punct = punct;
        repeat (2) @(negedge iclk);
        ireset = 1'b0;
        wq.delete();
    endtask

    task automatic stream(input int n, input int base, input int eop_idx,
                          input bit sop_ok, input logic [3:0] tag);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < n && guard < 100) begin
            @(negedge iclk);
            ival = 1'b1; idat = 8'(base + i); itag = tag;
            isop = sop_ok && (i == 0); ieop = (i == eop_idx);
            acc = ordy;
            @(posedge iclk);
            if (acc) i++;
            guard++;
        end
        @(negedge iclk);
        ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        n_checks++;
        if (i != n) $display("FAIL stream_accept: accepted %0d words, required %0d", i, n);
        else n_pass++;
    endtask

    task automatic pulse_empty;
        @(negedge iclk); iempty = 1'b1;
        @(negedge iclk); iempty = 1'b0;
    endtask

    task automatic test_reset;
        logic [20:0] got;
        ireset = 1'b1;
        #1;
        got = {ordy, owrite, ofull, oeop_err, owbuf, otag, owsel, owaddr};
        n_checks++;
        if (got !== 21'd0) $display("FAIL reset_outputs: got %h required 0", got);
        else n_pass++;
        n_checks++;
        if (owdat !== 8'd0) $display("FAIL reset_owdat: got %h required 0", owdat);
        else n_pass++;
        do_reset(2, 2, 0);
        repeat (4) @(negedge iclk);
        n_checks++;
        if (wq.size() !== 0) $display("FAIL reset_no_write: got %0d writes required 0", wq.size());
        else n_pass++;
        n_checks++;
        if (ordy !== 1'b1) $display("FAIL reset_then_rdy: got %b required 1", ordy);
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [20:0] e, got;
        do_reset(3, 2, 0);
        stream(6, 'h10, 5, 1, 4'h5);
        n_checks++;
        if (ofull !== 1'b0) $display("FAIL basic_ofull_early: got %b required 0", ofull);
        else n_pass++;
        @(negedge iclk);
        n_checks++;
        if (ofull !== 1'b1) $display("FAIL basic_ofull: got %b required 1", ofull);
        else n_pass++;
        n_checks++;
        if (wq.size() !== 6) $display("FAIL basic_count: got %0d required 6", wq.size());
        else n_pass++;
        for (int c = 0; c < 2; c++)
            for (int z = 0; z < 3; z++) begin
                e = exp_rec(1'b0, 3, c, z, 'h10 + c * 3 + z);
                got = (c * 3 + z < wq.size()) ? wq[c * 3 + z] : 'x;
                n_checks++;
                if (got !== e) $display("FAIL basic_write%0d: got %h required %h", c * 3 + z, got, e);
                else n_pass++;
            end
        n_checks++;
        if ({oeop_err, otag} !== 5'h05) $display("FAIL basic_err_tag: got %h required 05", {oeop_err, otag});
        else n_pass++;
    endtask

    task automatic test_col4;
        logic [20:0] e, got;
        do_reset(2, 5, 0);
        stream(10, 'h20, 9, 1, 4'h1);
        @(negedge iclk);
        n_checks++;
        if (wq.size() !== 10) $display("FAIL col4_count: got %0d required 10", wq.size());
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            e = exp_rec(1'b0, 2, k / 2, k % 2, 'h20 + k);
            got = (k < wq.size()) ? wq[k] : 'x;
            n_checks++;
            if (got !== e) $display("FAIL col4_write%0d: got %h required %h", k, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [20:0] e, got;
        bit rdy_seen = 0;
        do_reset(1, 2, 0);
        stream(2, 'h30, 1, 1, 4'h1);
        @(negedge iclk);
        stream(2, 'h40, 1, 1, 4'h2);
        @(negedge iclk);
        repeat (6) begin
            @(negedge iclk);
            if (ordy) rdy_seen = 1;
        end
        n_checks++;
        if (rdy_seen) $display("FAIL b2b_rdy_blocked: got ordy 1 required 0");
        else n_pass++;
        n_checks++;
        if ({ofull, otag} !== 5'h11) $display("FAIL b2b_full_tag: got %h required 11", {ofull, otag});
        else n_pass++;
        e = exp_rec(1'b1, 1, 0, 0, 'h40);
        got = (wq.size() > 2) ? wq[2] : 'x;
        n_checks++;
        if (got !== e) $display("FAIL b2b_frame2_buf: got %h required %h", got, e);
        else n_pass++;
        pulse_empty();
        n_checks++;
        if ({ofull, otag} !== 5'h12) $display("FAIL b2b_release1: got %h required 12", {ofull, otag});
        else n_pass++;
        stream(2, 'h50, 1, 1, 4'h3);
        @(negedge iclk);
        n_checks++;
        if (wq.size() !== 6) $display("FAIL b2b_count: got %0d required 6", wq.size());
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            e = exp_rec(1'b0, 1, k, 0, 'h50 + k);
            got = (k + 4 < wq.size()) ? wq[k + 4] : 'x;
            n_checks++;
            if (got !== e) $display("FAIL b2b_frame3_write%0d: got %h required %h", k, got, e);
            else n_pass++;
        end
        n_checks++;
        if (otag !== 4'h2) $display("FAIL b2b_oldest_tag: got %h required 2", otag);
        else n_pass++;
        pulse_empty();
        n_checks++;
        if ({ofull, otag} !== 5'h13) $display("FAIL b2b_release2: got %h required 13", {ofull, otag});
        else n_pass++;
        pulse_empty();
        n_checks++;
        if (ofull !== 1'b0) $display("FAIL b2b_empty: got %b required 0", ofull);
        else n_pass++;
    endtask

    task automatic test_eop_err;
        logic [20:0] e, got;
        int guard = 0;
        do_reset(3, 2, 0);
        stream(6, 'h60, 3, 1, 4'h6);
        n_checks++;
        if (oeop_err !== 1'b1) $display("FAIL eop_early_err: got %b required 1", oeop_err);
        else n_pass++;
        @(negedge iclk);
        n_checks++;
        if (wq.size() !== 6) $display("FAIL eop_early_count: got %0d required 6", wq.size());
        else n_pass++;
        e = exp_rec(1'b0, 3, 1, 2, 'h65);
        got = (wq.size() > 5) ? wq[5] : 'x;
        n_checks++;
        if (got !== e) $display("FAIL eop_early_last_write: got %h required %h", got, e);
        else n_pass++;
        while (!ordy && guard < 20) begin
            @(negedge iclk);
            guard++;
        end
        n_checks++;
        if (oeop_err !== 1'b0 || ordy !== 1'b1)
            $display("FAIL eop_err_clear: got err %b rdy %b required err 0 rdy 1", oeop_err, ordy);
        else n_pass++;
        stream(6, 'h70, 5, 0, 4'h7);
        n_checks++;
        if (oeop_err !== 1'b1) $display("FAIL sop_missing_err: got %b required 1", oeop_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [20:0] e, got;
        do_reset(3, 2, 0);
        stream(6, 'h80, 5, 1, 4'h7);
        @(negedge iclk);
        n_checks++;
        if ({ofull, otag} !== 5'h17) $display("FAIL rmid_pre: got %h required 17", {ofull, otag});
        else n_pass++;
        stream(3, 'h90, -1, 1, 4'h8);
        ireset = 1'b1;
        #1;
        got = {ordy, owrite, ofull, oeop_err, owbuf, otag, owsel, owaddr};
        n_checks++;
        if (got !== 21'd0 || owdat !== 8'd0)
            $display("FAIL rmid_outputs: got %h/%h required 0/0", got, owdat);
        else n_pass++;
        repeat (2) @(negedge iclk);
        ireset = 1'b0;
        wq.delete();
        repeat (4) @(negedge iclk);
        n_checks++;
        if (wq.size() !== 0) $display("FAIL rmid_no_write: got %0d writes required 0", wq.size());
        else n_pass++;
        stream(6, 'hA0, 5, 1, 4'h9);
        @(negedge iclk);
        e = exp_rec(1'b0, 3, 0, 0, 'hA0);
        got = (wq.size() > 0) ? wq[0] : 'x;
        n_checks++;
        if (got !== e || wq.size() !== 6)
            $display("FAIL rmid_new_frame: got %h (%0d writes) required %h (6 writes)", got, wq.size(), e);
        else n_pass++;
    endtask

    task automatic test_clkena_single;
        logic [20:0] e, got;
        bit moved = 0;
        do_reset(1, 1, 0);
        repeat (2) @(negedge iclk);
        iclkena = 1'b0;
        ival = 1'b1; idat = 8'hEE; isop = 1'b1; ieop = 1'b1;
        repeat (3) begin
            @(negedge iclk);
            if (owrite || !ordy) moved = 1;
        end
        ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        iclkena = 1'b1;
        n_checks++;
        if (moved || wq.size() !== 0) $display("FAIL clkena_freeze: got moved %b writes %0d required 0 0", moved, wq.size());
        else n_pass++;
        stream(1, 'hB0, 0, 1, 4'hB);
        @(negedge iclk);
        e = exp_rec(1'b0, 1, 0, 0, 'hB0);
        got = (wq.size() > 0) ? wq[0] : 'x;
        n_checks++;
        if (got !== e || wq.size() !== 1)
            $display("FAIL single_word: got %h (%0d writes) required %h (1 write)", got, wq.size(), e);
        else n_pass++;
        n_checks++;
        if ({ofull, oeop_err, otag} !== 6'h2B) $display("FAIL single_status: got %h required 2b", {ofull, oeop_err, otag});
        else n_pass++;
    endtask

`ifdef LDPC_3GPP_DEC_SOURCE_PUNCT_FILL_EN
    task automatic test_punct;
        logic [20:0] e, got;
        int lows = 0;
        do_reset(2, 4, 1);
        while (lows < 20) begin
            @(negedge iclk);
            if (ordy) break;
            lows++;
        end
        n_checks++;
        if (lows !== 4) $display("FAIL punct_rdy_low: got %0d cycles required 4", lows);
        else n_pass++;
        stream(4, 'hC0, 3, 1, 4'hC);
        @(negedge iclk);
        n_checks++;
        if (wq.size() !== 8) $display("FAIL punct_count: got %0d required 8", wq.size());
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            e = exp_rec(1'b0, 2, k / 2, k % 2, (k < 4) ? 0 : 'hC0 + k - 4);
            got = (k < wq.size()) ? wq[k] : 'x;
            n_checks++;
            if (got !== e) $display("FAIL punct_write%0d: got %h required %h", k, got, e);
            else n_pass++;
        end
    endtask
`else
    task automatic test_punct;
        logic [20:0] e, got;
        do_reset(1, 2, 1);
        stream(2, 'hD0, 1, 1, 4'hD);
        @(negedge iclk);
        n_checks++;
        if (wq.size() !== 2) $display("FAIL nopunct_count: got %0d required 2", wq.size());
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            e = exp_rec(1'b0, 1, k, 0, 'hD0 + k);
            got = (k < wq.size()) ? wq[k] : 'x;
            n_checks++;
            if (got !== e) $display("FAIL nopunct_write%0d: got %h required %h", k, got, e);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_col4();
        test_back_to_back();
        test_eop_err();
        test_reset_mid();
        test_clkena_single();
        test_punct();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
